// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter
//   Round-robin arbiter sharing one single-port data memory between the
//   processor MEM stage (requester 0) and the debug/load port (requester 1).
//   Each grant runs one burst of len+1 beats at consecutive (wrapping)
//   addresses. Every burst is followed by at least one idle cycle.
//
//   state | meaning
//   IDLE  | no owner; memory side quiet; arbitrating on req0/req1
//   BURST | owner holds gnt/ack; one beat per cycle until beat == len
//
// Ports
//   clock, reset             : posedge clock, async active-high reset
//   req*/we*/addr*/len*      : per-requester burst request and attributes
//   wdata*                   : per-requester write data for the current beat
//   gnt*/ack*                : ownership and per-beat acknowledge
//   rdata                    : read data during read-burst beats, else 0
//   mem*                     : memory control, address, write data, read data
//   busy                     : high while in BURST
module data_memory_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [LEN_WIDTH-1:0]  len0,
  input  logic [LEN_WIDTH-1:0]  len1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  memReadSignal,
  output logic                  memWriteSignal,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic [DATA_WIDTH-1:0] memWriteData,
  input  logic [DATA_WIDTH-1:0] memDataOut,
  output logic                  busy
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state_q;
  logic                  owner_q;
  logic                  last_q;
  logic [LEN_WIDTH-1:0]  beat_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;

  // On a tie the requester that was not served last wins; otherwise the
  // single requester wins (req1 alone -> 1, req0 alone -> 0).
  logic owner_d;
  always_comb begin
    owner_d = (req0 && req1) ? ~last_q : req1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      beat_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            owner_q <= owner_d;
            last_q  <= owner_d;
            we_q    <= owner_d ? we1   : we0;
            addr_q  <= owner_d ? addr1 : addr0;
            len_q   <= owner_d ? len1  : len0;
            beat_q  <= '0;
            state_q <= BURST;
          end
        end
        BURST: begin
          if (beat_q == len_q) state_q <= IDLE;
          else                 beat_q  <= beat_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // All outputs decode from the state registers, so they drop to zero the
  // moment reset forces IDLE.
  always_comb begin
    busy           = (state_q == BURST);
    gnt0           = busy && !owner_q;
    gnt1           = busy &&  owner_q;
    ack0           = gnt0;
    ack1           = gnt1;
    memWriteSignal = busy &&  we_q;
    memReadSignal  = busy && !we_q;
    memAddress     = busy ? (addr_q + ADDR_WIDTH'(beat_q)) : '0;
    memWriteData   = busy ? (owner_q ? wdata1 : wdata0) : '0;
    rdata          = memReadSignal ? memDataOut : '0;
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
module tb_data_memory_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       req0, req1, we0, we1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic [1:0] len0, len1;
  logic       gnt0, gnt1, ack0, ack1, memReadSignal, memWriteSignal, busy;
  logic [7:0] rdata, memAddress, memWriteData, memDataOut;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  data_memory_arbiter dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .len0(len0), .len1(len1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .rdata(rdata), .memReadSignal(memReadSignal), .memWriteSignal(memWriteSignal),
    .memAddress(memAddress), .memWriteData(memWriteData),
    .memDataOut(memDataOut), .busy(busy)
  );

  // Memory attached to the DUT
  logic [7:0] mem [256];
  assign memDataOut = mem[memAddress];
  always @(posedge clock) if (memWriteSignal) mem[memAddress] <= memWriteData;

  // Reference model: a queue of the beats still to be served, filled when a
  // grant is decided, plus a shadow copy of the memory contents.
  typedef struct {
    logic       own;
    logic       we;
    logic [7:0] addr;
  } beat_t;
  beat_t      exp_q[$];
  logic       m_last;
  logic [7:0] ref_mem [256];

  function automatic logic [30:0] obs_vec();
    return {gnt0, gnt1, ack0, ack1, busy, memReadSignal, memWriteSignal,
            memAddress, memWriteData, rdata};
  endfunction

  function automatic logic [30:0] exp_vec();
    beat_t b;
    logic [7:0] wd;
    if (reset || exp_q.size() == 0) return '0;
    b  = exp_q[0];
    wd = b.own ? wdata1 : wdata0;
    return {!b.own, b.own, !b.own, b.own, 1'b1, !b.we, b.we,
            b.addr, wd, b.we ? 8'h00 : ref_mem[b.addr]};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_last = 1'b1;
  endtask

  // Advance one clock; the model consumes a beat or arbitrates at the edge.
  task automatic tick();
    beat_t b;
    logic  own;
    int    n;
    @(posedge clock);
    if (!reset) begin
      if (exp_q.size() > 0) begin
        b = exp_q.pop_front();
        if (b.we) ref_mem[b.addr] = b.own ? wdata1 : wdata0;
      end else if (req0 || req1) begin
        own    = (req0 && req1) ? !m_last : req1;
        m_last = own;
        n      = (own ? int'(len1) : int'(len0)) + 1;
        for (int i = 0; i < n; i++) begin
          b.own  = own;
          b.we   = own ? we1 : we0;
          b.addr = (own ? addr1 : addr0) + 8'(i);
          exp_q.push_back(b);
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    mem[a]     = d;
    ref_mem[a] = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0 = 1; req1 = 1; we0 = 1; we1 = 0;
    addr0 = 8'h12; addr1 = 8'h34; len0 = 3; len1 = 3; wdata0 = 8'hAA; wdata1 = 8'h55;
    model_reset();
    repeat (2) @(negedge clock);
    tests_run++;
    if (obs_vec() !== 31'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h want 0", obs_vec());
    end
    req0 = 0; req1 = 0;
    reset = 1'b0;
    #1;
    tests_run++;
    if (obs_vec() !== 31'h0) begin
      tests_failed++;
      $display("FAIL post_reset_outputs: got %h want 0", obs_vec());
    end
  endtask

  task automatic test_single_write();
    req0 = 1; we0 = 1; addr0 = 8'h06; len0 = 0; wdata0 = 8'h09;
    tick();
    req0 = 0;
    #1;
    tests_run++;
    if (obs_vec() !== exp_vec() || !gnt0 || !ack0 || !memWriteSignal ||
        memAddress !== 8'h06 || memWriteData !== 8'h09) begin
      tests_failed++;
      $display("FAIL single_write_beat: got %h want %h", obs_vec(), exp_vec());
    end
    tick();
    tests_run++;
    if (busy !== 1'b0 || gnt0 !== 1'b0 || ack0 !== 1'b0 || mem[8'h06] !== 8'h09) begin
      tests_failed++;
      $display("FAIL single_write_end: busy=%b gnt0=%b ack0=%b mem[06]=%h want 0 0 0 09",
               busy, gnt0, ack0, mem[8'h06]);
    end
  endtask

  task automatic test_read_burst();
    logic [7:0] exp_rd [4];
    exp_rd[0] = 8'h08; exp_rd[1] = 8'h09; exp_rd[2] = 8'h01; exp_rd[3] = 8'h05;
    for (int i = 0; i < 4; i++) preload(8'(i), exp_rd[i]);
    req1 = 1; we1 = 0; addr1 = 8'h00; len1 = 3; wdata1 = 8'h77;
    tick();
    req1 = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if (obs_vec() !== exp_vec() || !ack1 || memWriteSignal !== 1'b0 ||
          memAddress !== 8'(i) || rdata !== exp_rd[i]) begin
        tests_failed++;
        $display("FAIL read_burst_beat%0d: addr=%h rdata=%h ack1=%b wr=%b want addr=%h rdata=%h ack1=1 wr=0",
                 i, memAddress, rdata, ack1, memWriteSignal, 8'(i), exp_rd[i]);
      end
      tick();
    end
    tests_run++;
    if (busy !== 1'b0 || ack1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_burst_end: busy=%b ack1=%b want 0 0", busy, ack1);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_a [4];
    exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00; exp_a[3] = 8'h01;
    req0 = 1; we0 = 1; addr0 = 8'hFE; len0 = 3;
    tick();
    req0 = 0;
    for (int i = 0; i < 4; i++) begin
      wdata0 = 8'($urandom);
      #1;
      tests_run++;
      if (obs_vec() !== exp_vec() || memAddress !== exp_a[i]) begin
        tests_failed++;
        $display("FAIL wrap_beat%0d: addr=%h want %h (vec %h vs %h)",
                 i, memAddress, exp_a[i], obs_vec(), exp_vec());
      end
      tick();
    end
    tests_run++;
    if (mem[8'h01] !== ref_mem[8'h01] || mem[8'hFE] !== ref_mem[8'hFE]) begin
      tests_failed++;
      $display("FAIL wrap_mem: mem[01]=%h mem[FE]=%h want %h %h",
               mem[8'h01], mem[8'hFE], ref_mem[8'h01], ref_mem[8'hFE]);
    end
  endtask

  task automatic test_contention();
    logic [1:0] pat [8];
    pat[0] = 2'b10; pat[1] = 2'b00; pat[2] = 2'b01; pat[3] = 2'b00;
    pat[4] = 2'b10; pat[5] = 2'b00; pat[6] = 2'b01; pat[7] = 2'b00;
    reset = 1'b1;
    model_reset();
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; len0 = 0; len1 = 0;
    addr0 = 8'h20; addr1 = 8'h30;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      #1;
      tests_run++;
      if ({gnt0, gnt1} !== pat[i] || obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL contention_cycle%0d: gnt0gnt1=%b want %b (vec %h vs %h)",
                 i, {gnt0, gnt1}, pat[i], obs_vec(), exp_vec());
      end
    end
    req0 = 0; req1 = 0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 4; i++) preload(8'h40 + 8'(i), 8'hA0 + 8'(i));
    req0 = 1; we0 = 1; addr0 = 8'h40; len0 = 3;
    tick();
    req0 = 0;
    wdata0 = 8'h11; tick();
    wdata0 = 8'h22; tick();
    wdata0 = 8'h33;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    tests_run++;
    if (obs_vec() !== 31'h0) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs: got %h want 0", obs_vec());
    end
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; len0 = 0; len1 = 0;
    @(negedge clock);
    tests_run++;
    if (mem[8'h40] !== 8'h11 || mem[8'h41] !== 8'h22 ||
        mem[8'h42] !== 8'hA2 || mem[8'h43] !== 8'hA3) begin
      tests_failed++;
      $display("FAIL mid_reset_mem: got %h %h %h %h want 11 22 a2 a3",
               mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]);
    end
    reset = 1'b0;
    tick();
    #1;
    tests_run++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || obs_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL mid_reset_first_grant: gnt0=%b gnt1=%b want 1 0", gnt0, gnt1);
    end
    req0 = 0; req1 = 0;
    tick();
    tick();
  endtask

  task automatic test_req_drop();
    int acks;
    req0 = 1; we0 = 0; addr0 = 8'h10; len0 = 2;
    tick();
    acks = ack0 ? 1 : 0;
    req0 = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ack0) acks++;
    end
    tests_run++;
    if (acks != 3 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL req_drop: acks=%0d busy=%b want 3 0", acks, busy);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      req0   = ($urandom_range(0, 2) != 0);
      req1   = ($urandom_range(0, 2) != 0);
      we0    = 1'($urandom);
      we1    = 1'($urandom);
      addr0  = 8'($urandom);
      addr1  = 8'($urandom);
      len0   = 2'($urandom);
      len1   = 2'($urandom);
      wdata0 = 8'($urandom);
      wdata1 = 8'($urandom);
      #1;
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL random_cycle%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      tick();
    end
    req0 = 0; req1 = 0;
    repeat (5) tick();
    for (int a = 0; a < 256; a++) begin
      if (mem[a] !== ref_mem[a]) begin
        tests_run++;
        tests_failed++;
        $display("FAIL random_mem[%0d]: got %h want %h", a, mem[a], ref_mem[a]);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) preload(8'(a), 8'(a * 7 + 3));
    test_reset();
    test_single_write();
    test_read_burst();
    test_wrap();
    test_contention();
    test_reset_mid_burst();
    test_req_drop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
